// File: rtl/fastram_pkg.sv
// Shared types and constants for the fast-RAM cycle controller.
// RAM_4MB_EN selects a two-bank (4MB) layout instead of the single 2MB bank.
package fastram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_SKIP = 2'd3
  } state_t;

`ifdef RAM_4MB_EN
  localparam int BANK_COUNT = 2;
`else
  localparam int BANK_COUNT = 1;
`endif

  localparam int WAIT_STATES_MAX = 7;

endpackage

// File: rtl/fastram_cycle_ctrl_if.sv
// 68000-side bus, autoconfig inputs and SRAM control pins of the fast-RAM controller.
// The CPU/board side drives through "master"; the controller uses "slave".
interface fastram_cycle_ctrl_if;
  logic       cpu_nas;
  logic       cpu_nuds;
  logic       cpu_nlds;
  logic       cpu_rnw;
  logic [2:0] AH;
  logic       ram_configured;
  logic [2:0] base_address;
  logic [1:0] ram_nce;
  logic       ram_noe;
  logic       ram_nwe_hi;
  logic       ram_nwe_lo;
  logic       dtack;
  logic       ram_busy;

  modport master (
    output cpu_nas, cpu_nuds, cpu_nlds, cpu_rnw, AH, ram_configured, base_address,
    input  ram_nce, ram_noe, ram_nwe_hi, ram_nwe_lo, dtack, ram_busy
  );

  modport slave (
    input  cpu_nas, cpu_nuds, cpu_nlds, cpu_rnw, AH, ram_configured, base_address,
    output ram_nce, ram_noe, ram_nwe_hi, ram_nwe_lo, dtack, ram_busy
  );
endinterface

// File: rtl/fastram_decode.sv
// Combinational hit/bank decode of A[23:21] against the autoconfigured base.
// With RAM_4MB_EN the window doubles and A21 selects the bank.
module fastram_decode (
  input  logic [2:0] ah_i,
  input  logic       ram_configured_i,
  input  logic [2:0] base_address_i,
  output logic       hit_o,
  output logic       bank_o
);

`ifdef RAM_4MB_EN
  // Base is 4MB aligned, so its A21 bit carries no information here.
  logic unused_base_lsb;
  assign unused_base_lsb = base_address_i[0];
  assign hit_o  = ram_configured_i && (ah_i[2:1] == base_address_i[2:1]);
  assign bank_o = ah_i[0];
`else
  assign hit_o  = ram_configured_i && (ah_i == base_address_i);
  assign bank_o = 1'b0;
`endif

endmodule

// File: rtl/fastram_cycle_ctrl.sv
// Sequences 68000 bus cycles onto the on-board fast SRAM with programmable wait states.
// Build option: RAM_4MB_EN enables the second 2MB bank (ram_nce[1]).
module fastram_cycle_ctrl
  import fastram_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input logic                  cpu_clk,
  input logic                  cpu_nreset,
  fastram_cycle_ctrl_if.slave  bus
);

  localparam int WS = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX :
                      (WAIT_STATES < 0) ? 0 : WAIT_STATES;
  localparam logic [2:0] WS_LOAD = (WS == 0) ? 3'd0 : 3'(WS - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       bank_q, bank_d;
  logic       rnw_q, rnw_d;
  logic       hit, bank;
  logic       active;
  logic [1:0] ram_nce_w;

  fastram_decode u_decode (
    .ah_i             (bus.AH),
    .ram_configured_i (bus.ram_configured),
    .base_address_i   (bus.base_address),
    .hit_o            (hit),
    .bank_o           (bank)
  );

  always_ff @(posedge cpu_clk or negedge cpu_nreset) begin
    if (!cpu_nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      bank_q  <= 1'b0;
      rnw_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      rnw_q   <= rnw_d;
    end
  end

  // Decode happens only out of IDLE, so a cycle that turns into a hit late stays in SKIP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    rnw_d   = rnw_q;
    if (bus.cpu_nas) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hit) begin
            state_d = (WS > 0) ? ST_WAIT : ST_ACK;
            cnt_d   = WS_LOAD;
            bank_d  = bank;
            rnw_d   = bus.cpu_rnw;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 3'd0) state_d = ST_ACK;
          else               cnt_d   = cnt_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Gating with /AS lets the SRAM strobes drop without waiting for the next clock edge.
  assign active = ((state_q == ST_WAIT) || (state_q == ST_ACK)) && !bus.cpu_nas;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    if (gi < BANK_COUNT) begin : g_used
      assign ram_nce_w[gi] = ~(active && (bank_q == 1'(gi)));
    end else begin : g_tied
      assign ram_nce_w[gi] = 1'b1;
    end
  end

  assign bus.ram_nce    = ram_nce_w;
  assign bus.ram_noe    = ~(active && rnw_q);
  assign bus.ram_nwe_hi = ~(active && !rnw_q && !bus.cpu_nuds);
  assign bus.ram_nwe_lo = ~(active && !rnw_q && !bus.cpu_nlds);
  assign bus.dtack      = (state_q == ST_ACK);
  assign bus.ram_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fastram_cycle_ctrl.sv
// Directed bench for fastram_cycle_ctrl: one instance with 0 and one with 2 wait states
// share the same bus stimulus; outputs are packed as {nce[1:0], noe, nwe_hi, nwe_lo, dtack, busy}.
module tb_fastram_cycle_ctrl;

  logic       clk;
  logic       nreset;
  logic       nas, nuds, nlds, rnw, cfg;
  logic [2:0] ah, base;
  int         checks;
  int         errors;

  fastram_cycle_ctrl_if bus0 ();
  fastram_cycle_ctrl_if bus2 ();

  assign bus0.cpu_nas = nas;   assign bus2.cpu_nas = nas;
  assign bus0.cpu_nuds = nuds; assign bus2.cpu_nuds = nuds;
  assign bus0.cpu_nlds = nlds; assign bus2.cpu_nlds = nlds;
  assign bus0.cpu_rnw = rnw;   assign bus2.cpu_rnw = rnw;
  assign bus0.AH = ah;         assign bus2.AH = ah;
  assign bus0.ram_configured = cfg; assign bus2.ram_configured = cfg;
  assign bus0.base_address = base;  assign bus2.base_address = base;

  fastram_cycle_ctrl #(.WAIT_STATES(0)) dut0 (.cpu_clk(clk), .cpu_nreset(nreset), .bus(bus0));
  fastram_cycle_ctrl #(.WAIT_STATES(2)) dut2 (.cpu_clk(clk), .cpu_nreset(nreset), .bus(bus2));

  logic [6:0] snap0, snap2;
  assign snap0 = {bus0.ram_nce, bus0.ram_noe, bus0.ram_nwe_hi, bus0.ram_nwe_lo, bus0.dtack, bus0.ram_busy};
  assign snap2 = {bus2.ram_nce, bus2.ram_noe, bus2.ram_nwe_hi, bus2.ram_nwe_lo, bus2.dtack, bus2.ram_busy};

  localparam logic [6:0] S_IDLE     = 7'b11_111_00;
  localparam logic [6:0] S_SKIP     = 7'b11_111_01;
  localparam logic [6:0] S_RD_WAIT  = 7'b10_011_01;
  localparam logic [6:0] S_RD_ACK   = 7'b10_011_11;
  localparam logic [6:0] S_ACK_ASHI = 7'b11_111_11;
  localparam logic [6:0] S_WR_WAIT  = 7'b10_111_01;
  localparam logic [6:0] S_WRL_WAIT = 7'b10_110_01;
  localparam logic [6:0] S_WRL_ACK  = 7'b10_110_11;
  localparam logic [6:0] S_RD1_ACK  = 7'b01_011_11;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    nas = 1'b1; nuds = 1'b1; nlds = 1'b1; rnw = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; cfg = 1'b1; base = 3'b001; ah = 3'b000;
    bus_idle();
    #2;
    checks++;
    if (snap0 !== S_IDLE) begin errors++; $display("FAIL reset_ws0 got %b want %b", snap0, S_IDLE); end
    checks++;
    if (snap2 !== S_IDLE) begin errors++; $display("FAIL reset_ws2 got %b want %b", snap2, S_IDLE); end
    tick(); tick();
    nreset = 1'b1;
    tick();
    checks++;
    if (snap0 !== S_IDLE) begin errors++; $display("FAIL post_reset got %b want %b", snap0, S_IDLE); end
  endtask

  task automatic test_read();
    ah = 3'b001; rnw = 1'b1; nas = 1'b0; nuds = 1'b0; nlds = 1'b0;
    #1;
    checks++;
    if (snap0 !== S_IDLE) begin errors++; $display("FAIL read_pre_edge got %b want %b", snap0, S_IDLE); end
    tick();
    checks++;
    if (snap0 !== S_RD_ACK) begin errors++; $display("FAIL read_ws0_edge1 got %b want %b", snap0, S_RD_ACK); end
    checks++;
    if (snap2 !== S_RD_WAIT) begin errors++; $display("FAIL read_ws2_edge1 got %b want %b", snap2, S_RD_WAIT); end
    tick();
    checks++;
    if (snap2 !== S_RD_WAIT) begin errors++; $display("FAIL read_ws2_edge2 got %b want %b", snap2, S_RD_WAIT); end
    tick();
    checks++;
    if (snap2 !== S_RD_ACK) begin errors++; $display("FAIL read_ws2_edge3 got %b want %b", snap2, S_RD_ACK); end
    nas = 1'b1;
    #1;
    checks++;
    if (snap0 !== S_ACK_ASHI) begin errors++; $display("FAIL read_as_rise got %b want %b", snap0, S_ACK_ASHI); end
    bus_idle();
    tick();
    checks++;
    if (snap0 !== S_IDLE) begin errors++; $display("FAIL read_end_ws0 got %b want %b", snap0, S_IDLE); end
    checks++;
    if (snap2 !== S_IDLE) begin errors++; $display("FAIL read_end_ws2 got %b want %b", snap2, S_IDLE); end
  endtask

  task automatic test_byte_write();
    ah = 3'b001; rnw = 1'b0; nas = 1'b0;
    tick();
    checks++;
    if (snap2 !== S_WR_WAIT) begin errors++; $display("FAIL wr_before_lds got %b want %b", snap2, S_WR_WAIT); end
    nlds = 1'b0;
    #1;
    checks++;
    if (snap2 !== S_WRL_WAIT) begin errors++; $display("FAIL wr_lds_only got %b want %b", snap2, S_WRL_WAIT); end
    tick();
    checks++;
    if (snap2 !== S_WRL_WAIT) begin errors++; $display("FAIL wr_ws2_edge2 got %b want %b", snap2, S_WRL_WAIT); end
    tick();
    checks++;
    if (snap2 !== S_WRL_ACK) begin errors++; $display("FAIL wr_ws2_ack got %b want %b", snap2, S_WRL_ACK); end
    nas = 1'b1;
    #1;
    checks++;
    if (snap2 !== S_ACK_ASHI) begin errors++; $display("FAIL wr_as_rise got %b want %b", snap2, S_ACK_ASHI); end
    bus_idle();
    tick();
    checks++;
    if (snap2 !== S_IDLE) begin errors++; $display("FAIL wr_end got %b want %b", snap2, S_IDLE); end
  endtask

  task automatic test_miss();
    for (int i = 0; i < 2; i++) begin
      ah  = (i == 0) ? 3'b010 : 3'b001;
      cfg = (i == 0) ? 1'b1 : 1'b0;
      nas = 1'b0; nuds = 1'b0; nlds = 1'b0;
      tick();
      checks++;
      if (snap0 !== S_SKIP) begin errors++; $display("FAIL miss%0d_ws0 got %b want %b", i, snap0, S_SKIP); end
      tick();
      checks++;
      if (snap2 !== S_SKIP) begin errors++; $display("FAIL miss%0d_ws2 got %b want %b", i, snap2, S_SKIP); end
      bus_idle();
      tick();
      checks++;
      if (snap0 !== S_IDLE) begin errors++; $display("FAIL miss%0d_end got %b want %b", i, snap0, S_IDLE); end
    end
    cfg = 1'b1;
  endtask

  task automatic test_midcycle_config();
    cfg = 1'b0; ah = 3'b001; nas = 1'b0; nuds = 1'b0; nlds = 1'b0;
    tick();
    cfg = 1'b1;
    tick();
    checks++;
    if (snap0 !== S_SKIP) begin errors++; $display("FAIL late_cfg_no_service got %b want %b", snap0, S_SKIP); end
    bus_idle();
    tick();
    nas = 1'b0; nuds = 1'b0; nlds = 1'b0;
    tick();
    checks++;
    if (snap0 !== S_RD_ACK) begin errors++; $display("FAIL late_cfg_next_hit got %b want %b", snap0, S_RD_ACK); end
    bus_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    ah = 3'b001; nas = 1'b0; nuds = 1'b0; nlds = 1'b0;
    tick();
    checks++;
    if (snap0 !== S_RD_ACK) begin errors++; $display("FAIL b2b_first got %b want %b", snap0, S_RD_ACK); end
    nas = 1'b1;
    tick();
    checks++;
    if (snap0 !== S_IDLE) begin errors++; $display("FAIL b2b_gap got %b want %b", snap0, S_IDLE); end
    nas = 1'b0;
    tick();
    checks++;
    if (snap0 !== S_RD_ACK) begin errors++; $display("FAIL b2b_second got %b want %b", snap0, S_RD_ACK); end
    bus_idle();
    tick();
  endtask

  task automatic test_reset_midwait();
    ah = 3'b001; nas = 1'b0; nuds = 1'b0; nlds = 1'b0;
    tick();
    checks++;
    if (snap2 !== S_RD_WAIT) begin errors++; $display("FAIL rst_in_wait got %b want %b", snap2, S_RD_WAIT); end
    #1;
    nreset = 1'b0;
    #1;
    checks++;
    if (snap2 !== S_IDLE) begin errors++; $display("FAIL rst_midwait got %b want %b", snap2, S_IDLE); end
    tick();
    checks++;
    if (snap2 !== S_IDLE) begin errors++; $display("FAIL rst_held got %b want %b", snap2, S_IDLE); end
    bus_idle();
    nreset = 1'b1;
    tick();
    checks++;
    if (snap2 !== S_IDLE) begin errors++; $display("FAIL rst_release got %b want %b", snap2, S_IDLE); end
  endtask

  task automatic test_4mb();
    logic [6:0] exp_a, exp_b, exp_c;
    base = 3'b010;
`ifdef RAM_4MB_EN
    exp_a = S_RD_ACK; exp_b = S_RD1_ACK; exp_c = S_SKIP;
`else
    exp_a = S_RD_ACK; exp_b = S_SKIP; exp_c = S_SKIP;
`endif
    for (int i = 0; i < 3; i++) begin
      ah = (i == 0) ? 3'b010 : (i == 1) ? 3'b011 : 3'b100;
      nas = 1'b0; nuds = 1'b0; nlds = 1'b0;
      tick();
      checks++;
      if (i == 0 && snap0 !== exp_a) begin errors++; $display("FAIL bank_ah010 got %b want %b", snap0, exp_a); end
      if (i == 1 && snap0 !== exp_b) begin errors++; $display("FAIL bank_ah011 got %b want %b", snap0, exp_b); end
      if (i == 2 && snap0 !== exp_c) begin errors++; $display("FAIL bank_ah100 got %b want %b", snap0, exp_c); end
      bus_idle();
      tick();
    end
    base = 3'b001;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_read();
    test_byte_write();
    test_miss();
    test_midcycle_config();
    test_back_to_back();
    test_reset_midwait();
    test_4mb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
